nibble_seq_adder: RTL and testbench

//   Sequencing stage that sits directly upstream of the 4-bit ripple adder (fullAdder).

---
 rtl/nibble_seq_adder_pkg.sv | 11 +
 rtl/nibble_seq_adder_full_adder.sv | 27 ++
 rtl/nibble_seq_adder.sv | 128 ++++++++++++
 tb/tb_nibble_seq_adder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/nibble_seq_adder_pkg.sv
// Shared constants and state encoding for the nibble-serial adder.
package nibble_seq_adder_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/nibble_seq_adder_full_adder.sv
// Existing 4-bit ripple-carry adder; purely combinational.
module fullAdder
  import nibble_seq_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                cin_i,
  output logic [NIBBLE_W-1:0] sum_c,
  output logic                cout_c
);

  logic [NIBBLE_W:0] carry_c;

  // Bit-by-bit ripple of the carry through the nibble.
  always_comb begin
    sum_c      = '0;
    carry_c    = '0;
    carry_c[0] = cin_i;
    for (int i = 0; i < int'(NIBBLE_W); i++) begin
      sum_c[i]       = a_i[i] ^ b_i[i] ^ carry_c[i];
      carry_c[i + 1] = (a_i[i] & b_i[i]) | (carry_c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign cout_c = carry_c[NIBBLE_W];

endmodule

// File: rtl/nibble_seq_adder.sv
// Wide unsigned adder that time-multiplexes one 4-bit adder, LSB nibble first.
module nibble_seq_adder
  import nibble_seq_adder_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NIBBLE_W*NIBBLES-1:0]  A,
  input  logic [NIBBLE_W*NIBBLES-1:0]  B,
  input  logic                         Cin,
  output logic                         busy,
  output logic                         done,
  output logic [NIBBLE_W*NIBBLES-1:0]  Sum,
  output logic                         Cout
);

  localparam int unsigned W  = NIBBLE_W * NIBBLES;
  localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);
  localparam logic [W-1:0]  NIB_MASK = W'({NIBBLE_W{1'b1}});

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  op_a_q, op_a_d;
  logic [W-1:0]  op_b_q, op_b_d;
  logic [W-1:0]  shadow_q, shadow_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [31:0]         base_c;
  logic [NIBBLE_W-1:0] nib_a_c, nib_b_c, add_sum_c;
  logic                add_cout_c;
  logic [W-1:0]        merged_c;

  // Nibble-select muxes feeding the shared adder.
  assign base_c  = 32'(idx_q) * 32'(NIBBLE_W);
  assign nib_a_c = NIBBLE_W'(op_a_q >> base_c);
  assign nib_b_c = NIBBLE_W'(op_b_q >> base_c);

  fullAdder u_full_adder (
    .a_i    (nib_a_c),
    .b_i    (nib_b_c),
    .cin_i  (carry_q),
    .sum_c  (add_sum_c),
    .cout_c (add_cout_c)
  );

  // Shadow with the current nibble's sum dropped into place.
  assign merged_c = (shadow_q & ~(NIB_MASK << base_c)) | (W'(add_sum_c) << base_c);

  // Control FSM and datapath next-state.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    shadow_d = shadow_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_a_d  = A;
          op_b_d  = B;
          carry_d = Cin;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        shadow_d = merged_c;
        carry_d  = add_cout_c;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          sum_d   = merged_c;
          cout_d  = add_cout_c;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      shadow_q <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      shadow_q <= shadow_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Sum  = sum_q;
  assign Cout = cout_q;

endmodule

// File: tb/tb_nibble_seq_adder.sv
// Self-checking bench for nibble_seq_adder with NIBBLES=4.
module tb_nibble_seq_adder;

  localparam int NIB = 4;
  localparam int W   = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] A, B;
  logic         Cin;
  logic         busy, done;
  logic [W-1:0] Sum;
  logic         Cout;

  always #5 clk = ~clk;

  nibble_seq_adder #(.NIBBLES(NIB)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .busy  (busy),
    .done  (done),
    .Sum   (Sum),
    .Cout  (Cout)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
  } exp_t;

  exp_t sb_q[$];
  exp_t e_mon;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Scoreboard: every done pulse must match the oldest accepted operation.
  always @(negedge clk) begin
    if (reset === 1'b0 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1, expected no pending op (t=%0t)", $time);
      end else begin
        e_mon = sb_q.pop_front();
        chk("sum", 32'(Sum), 32'(e_mon.s));
        chk("cout", 32'(Cout), 32'(e_mon.co));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  // Drive one accepted op from an idle negedge and wait for its done pulse.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic [W-1:0] es, input logic eco);
    exp_t e;
    int   bc;
    bit   got;
    A = a; B = b; Cin = c; start = 1'b1;
    e.s = es; e.co = eco;
    sb_q.push_back(e);
    bc = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) got = 1'b1;
      else if (busy === 1'b1) bc++;
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("busy_cycles", 32'(bc), 32'(NIB));
    chk("busy_at_done", 32'(busy), 32'd0);
  endtask

  vec_t         vecs[8];
  logic [W:0]   r;
  logic [W-1:0] ra, rb;
  logic         rc;
  int           bc;
  bit           got;
  exp_t         e;

  initial begin
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[3] = '{16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0};
    vecs[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[6] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};
    vecs[7] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0};

    // Reset held two cycles with start high: outputs stay cleared.
    reset = 1'b1; start = 1'b1; A = 16'h1234; B = 16'h4321; Cin = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum", 32'(Sum), 32'd0);
      chk("rst_cout", 32'(Cout), 32'd0);
    end
    reset = 1'b0; start = 1'b0;
    @(negedge clk);

    // Directed vector table.
    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].co);

    // Start while busy is ignored: one done with the first result only.
    A = 16'h0001; B = 16'h0001; Cin = 1'b0; start = 1'b1;
    e.s = 16'h0002; e.co = 1'b0;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 16'hAAAA; B = 16'h1111; Cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (done === 1'b1) got = 1'b1;
    end
    chk("ignored_done_seen", 32'(got), 32'd1);
    repeat (8) @(negedge clk);
    chk("ignored_busy", 32'(busy), 32'd0);
    chk("ignored_queue", 32'(sb_q.size()), 32'd0);

    // Start in the done cycle is accepted; Sum holds the old value meanwhile.
    run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    A = 16'h0F0F; B = 16'h00F1; Cin = 1'b1; start = 1'b1;
    e.s = 16'h1001; e.co = 1'b0;
    sb_q.push_back(e);
    bc = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) got = 1'b1;
      else if (busy === 1'b1) begin
        bc++;
        chk("hold_sum", 32'(Sum), 32'h5555);
      end
    end
    chk("b2b_done_seen", 32'(got), 32'd1);
    chk("b2b_busy_cycles", 32'(bc), 32'(NIB));

    // Random operands against an arithmetic model.
    for (int i = 0; i < 12; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      r  = {1'b0, ra} + {1'b0, rb} + (W+1)'(rc);
      run_op(ra, rb, rc, r[W-1:0], r[W]);
    end

    // Reset two cycles into RUN aborts the op with no done pulse.
    A = 16'hFFFF; B = 16'hFFFF; Cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(Sum), 32'd0);
    chk("abort_cout", 32'(Cout), 32'd0);
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
    end
    run_op(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0);

    repeat (4) @(negedge clk);
    chk("final_queue", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
